// File: rtl/ysyx_24110026_seq_ctrl.sv
// Multi-cycle instruction sequencer for the RV32E NPC core: fetch/decode/exec/mem/wb
// with fetch and load/store handshakes, retire counters, ebreak halt and response timeout.
module ysyx_24110026_seq_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_ifu_req,
  input  logic             i_ifu_rvalid,
  input  logic [31:0]      i_ifu_rdata,
  output logic [31:0]      o_inst_q,
  input  logic             i_dec_mem,
  input  logic             i_dec_store,
  input  logic             i_dec_wb,
  input  logic             i_dec_ebreak,
  output logic             o_lsu_req,
  output logic             o_lsu_we,
  input  logic             i_lsu_gnt,
  input  logic             i_lsu_rvalid,
  output logic             o_pc_we,
  output logic             o_rf_we,
  output logic             o_halt,
  output logic             o_err,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instret_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM_REQ = 3'd4, S_MEM_WAIT = 3'd5, S_WB = 3'd6, S_HALT = 3'd7
  } state_t;

  state_t            r_state, w_nxt;
  logic [15:0]       r_wcnt;
  logic              r_mem, r_store, r_wb;
  logic              r_ifu_req, r_lsu_req, r_lsu_we, r_pc_we, r_rf_we, r_halt, r_err;
  logic [31:0]       r_inst_q;
  logic [CNT_W-1:0]  r_cycle_cnt, r_instret_cnt;
  logic              w_hit, w_wait, w_to;

  always_comb begin
    w_nxt  = r_state;
    w_wait = 1'b0;
    w_to   = 1'b0;
    w_hit  = (r_wcnt == 16'(TIMEOUT - 1));
    case (r_state)
      S_IDLE:   w_nxt = S_FETCH;
      S_FETCH:
        if (i_ifu_rvalid) w_nxt = S_DECODE;
        else begin
          w_wait = 1'b1;
          if (w_hit) begin w_nxt = S_HALT; w_to = 1'b1; end
        end
      S_DECODE: w_nxt = i_dec_ebreak ? S_HALT : S_EXEC;
      S_EXEC:   w_nxt = r_mem ? S_MEM_REQ : S_WB;
      S_MEM_REQ:
        if (i_lsu_gnt) w_nxt = S_MEM_WAIT;
        else begin
          w_wait = 1'b1;
          if (w_hit) begin w_nxt = S_HALT; w_to = 1'b1; end
        end
      S_MEM_WAIT:
        if (i_lsu_rvalid) w_nxt = S_WB;
        else begin
          w_wait = 1'b1;
          if (w_hit) begin w_nxt = S_HALT; w_to = 1'b1; end
        end
      S_WB:     w_nxt = S_FETCH;
      S_HALT:   w_nxt = S_HALT;
      default:  w_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_wcnt        <= '0;
      r_mem         <= 1'b0;
      r_store       <= 1'b0;
      r_wb          <= 1'b0;
      r_ifu_req     <= 1'b0;
      r_lsu_req     <= 1'b0;
      r_lsu_we      <= 1'b0;
      r_pc_we       <= 1'b0;
      r_rf_we       <= 1'b0;
      r_halt        <= 1'b0;
      r_err         <= 1'b0;
      r_inst_q      <= '0;
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      r_state   <= w_nxt;
      r_ifu_req <= (w_nxt == S_FETCH);
      r_lsu_req <= (w_nxt == S_MEM_REQ);
      r_lsu_we  <= (w_nxt == S_MEM_REQ) && r_store;
      r_pc_we   <= (w_nxt == S_WB);
      r_rf_we   <= (w_nxt == S_WB) && r_wb && !r_store;
      r_halt    <= (w_nxt == S_HALT);
      r_err     <= r_err | w_to;
      if (r_state == S_FETCH && i_ifu_rvalid) r_inst_q <= i_ifu_rdata;
      if (r_state == S_DECODE) begin
        r_mem   <= i_dec_mem;
        r_store <= i_dec_store;
        r_wb    <= i_dec_wb;
      end
      // Not cleared between MEM_REQ and MEM_WAIT: one budget covers the whole access.
      if ((w_nxt == S_FETCH && r_state != S_FETCH) ||
          (w_nxt == S_MEM_REQ && r_state != S_MEM_REQ))
        r_wcnt <= '0;
      else if (w_wait && !w_to)
        r_wcnt <= r_wcnt + 16'd1;
      if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (r_state == S_WB) r_instret_cnt <= r_instret_cnt + 1'b1;
    end
  end

  assign o_ifu_req     = r_ifu_req;
  assign o_inst_q      = r_inst_q;
  assign o_lsu_req     = r_lsu_req;
  assign o_lsu_we      = r_lsu_we;
  assign o_pc_we       = r_pc_we;
  assign o_rf_we       = r_rf_we;
  assign o_halt        = r_halt;
  assign o_err         = r_err;
  assign o_state       = r_state;
  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_instret_cnt = r_instret_cnt;

endmodule

// File: doc/ysyx_24110026_seq_ctrl.md
# ysyx_24110026_seq_ctrl

Multi-cycle sequencer for the RV32E NPC core. It steps each instruction through fetch, decode, execute, optional memory access and write-back. It drives the instruction-fetch and load/store handshakes, gates the PC and register-file write enables, and latches the current instruction for the decoder. It also maintains cycle and retired-instruction counters, halts on `ebreak`, and halts with an error flag if a memory response times out.

## Interface
- `CNT_W`, default 32: width of `cycle_cnt` and `instret_cnt`.
- `TIMEOUT`, default 255: maximum wait cycles in FETCH or MEM_WAIT before error halt. Legal range 1..65535.

- `clk`  in  1  core clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `ifu_req`  out  1  instruction fetch request for the PC currently held by the PC register.
- `ifu_rvalid`  in  1  instruction returned on `ifu_rdata` this cycle.
- `ifu_rdata`  in  32  fetched instruction.
- `inst_q`  out  32  latched instruction, feeds the decoder.
- `dec_mem`  in  1  decoder: instruction is a load or store (valid in DECODE).
- `dec_store`  in  1  decoder: instruction is a store.
- `dec_wb`  in  1  decoder: instruction writes rd.
- `dec_ebreak`  in  1  decoder: instruction is `ebreak`.
- `lsu_req`  out  1  data memory request.
- `lsu_we`  out  1  request is a write. Equals latched `dec_store`.
- `lsu_gnt`  in  1  request accepted this cycle.
- `lsu_rvalid`  in  1  load data / store completion returned.
- `pc_we`  out  1  one-cycle PC update strobe.
- `rf_we`  out  1  one-cycle register-file write strobe.
- `halt`  out  1  sticky halt.
- `err`  out  1  sticky timeout error (implies `halt`).
- `state_o`  out  3  current state encoding, for debug/trace.
- `cycle_cnt`  out  CNT_W  cycles since reset.
- `instret_cnt`  out  CNT_W  retired instructions.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM_REQ=4, MEM_WAIT=5, WB=6, HALT=7.
- IDLE: always moves to FETCH next cycle.
- FETCH: `ifu_req`=1.
  - If `ifu_rvalid`: `inst_q`<=`ifu_rdata`, go to DECODE.
- DECODE: sample `dec_*` into internal flags.
  - If `dec_ebreak`: go to HALT with `err`=0.
  - Otherwise go to EXEC.
- EXEC: one cycle for ALU settling.
  - If the mem flag is set, go to MEM_REQ; otherwise go to WB.
- MEM_REQ: `lsu_req`=1 and `lsu_we`=store flag.
  - Hold both until `lsu_gnt`=1, then go to MEM_WAIT.
- MEM_WAIT: wait for `lsu_rvalid`=1, then go to WB.
  - `lsu_rvalid` seen in the MEM_REQ grant cycle is ignored.
- WB: `pc_we`=1; `rf_we`=wb flag AND NOT store flag; `instret_cnt`+=1; then go to FETCH.
- HALT: terminal. All strobes and requests are 0 and the counters freeze. Only `rst` exits.
- Wait counter:
  - Clears on entry to FETCH and MEM_REQ.
  - Increments each cycle in FETCH (without `ifu_rvalid`), MEM_REQ (without `lsu_gnt`) and MEM_WAIT (without `lsu_rvalid`).
  - When it reaches TIMEOUT with the awaited signal still low, go to HALT with `err`=1 and `halt`=1.
  - The MEM_REQ to MEM_WAIT transition does not clear it, so TIMEOUT bounds the whole memory access.
- Counters: `cycle_cnt` increments every cycle in any state other than HALT. Both counters wrap modulo 2^CNT_W without flagging.
- All outputs are decoded from registered state and flags. No combinational path from any input to any output.

## Timing
- Reset values: state=IDLE, `inst_q`=0, `ifu_req`=0, `lsu_req`=0, `lsu_we`=0, `pc_we`=0, `rf_we`=0, `halt`=0, `err`=0, `cycle_cnt`=0, `instret_cnt`=0, wait counter=0, flags=0.
- `rst` asserted in any state, including mid-handshake, forces reset values on the next edge. An outstanding request is dropped and the memory side must tolerate this.
- Latency with zero-wait responses:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Memory instruction: 6 cycles (grant in the first MEM_REQ cycle, rvalid in the first MEM_WAIT cycle).
- Handshake rules:
  - `ifu_req` and `lsu_req` stay high continuously until accepted.
  - `ifu_rvalid` outside FETCH and `lsu_gnt`/`lsu_rvalid` outside their states are ignored.
- `pc_we` and `rf_we` are high for exactly one cycle per retired instruction.
- `ebreak` does not retire: no `pc_we`, and `instret_cnt` does not increment.
- When the timeout threshold is reached in FETCH, `ifu_rvalid` arriving in that same cycle wins. The same applies to `lsu_gnt`/`lsu_rvalid` in the memory states.

## Test plan
- Reset, then `addi` returned with `ifu_rvalid` in the first FETCH cycle → state sequence 0,1,2,3,6,1. `pc_we`=`rf_we`=1 in cycle 5 after reset release; `instret_cnt`=1.
- Load, `lsu_gnt` after 2 wait cycles, `lsu_rvalid` 3 cycles later → `lsu_req` high for exactly 3 cycles with `lsu_we`=0. `rf_we` pulses once, 1 cycle after rvalid.
- Store with `dec_wb`=1 → `lsu_we`=1, `rf_we` stays 0, `pc_we` pulses once.
- `ebreak` (0x00100073) fetched → HALT reached 2 cycles after fetch. `halt`=1, `err`=0, `instret_cnt` unchanged, `cycle_cnt` frozen over 10 further cycles.
- TIMEOUT=4, `ifu_rvalid` held low → `halt`=`err`=1 after the 4th FETCH wait cycle. Repeat with `ifu_rvalid` raised on that exact cycle → proceeds to DECODE and no error.
- `rst` pulsed during MEM_WAIT → all outputs return to reset values the next cycle. IDLE then FETCH follows, and `cycle_cnt` restarts from 0.
